// File: rtl/ima_adpcm_pkg.sv
// Shared IMA ADPCM definitions: step/index tables, predictor limits and the
// per-channel decoder context type used by the step datapath and scheduler.
package ima_adpcm_pkg;

  localparam int STEP_IDX_MAX = 88;

  localparam logic signed [16:0] PRED_MIN = -17'sd32768;
  localparam logic signed [16:0] PRED_MAX = 17'sd32767;

  // Decoder context: predictor kept one bit wider than the sample so the
  // saturated value always fits with its sign.
  typedef struct packed {
    logic signed [16:0] pred;
    logic [6:0]         idx;
  } ima_ctx_t;

  localparam int STEP_TABLE [89] = '{
        7,     8,     9,    10,    11,    12,    13,    14,    16,    17,
       19,    21,    23,    25,    28,    31,    34,    37,    41,    45,
       50,    55,    60,    66,    73,    80,    88,    97,   107,   118,
      130,   143,   157,   173,   190,   209,   230,   253,   279,   307,
      337,   371,   408,   449,   494,   544,   598,   658,   724,   796,
      876,   963,  1060,  1166,  1282,  1411,  1552,  1707,  1878,  2066,
     2272,  2499,  2749,  3024,  3327,  3660,  4026,  4428,  4871,  5358,
     5894,  6484,  7132,  7845,  8630,  9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };

  localparam int INDEX_TABLE [16] = '{
    -1, -1, -1, -1, 2, 4, 6, 8,
    -1, -1, -1, -1, 2, 4, 6, 8
  };

endpackage

// File: rtl/ima_adpcm_step.sv
// One combinational IMA ADPCM decode step: context + nibble -> next context
// and the 16-bit output sample. Shared with the single-channel decoder.
module ima_adpcm_step
  import ima_adpcm_pkg::*;
(
  input  ima_ctx_t    ctx_i,
  input  logic [3:0]  nibble_i,
  output ima_ctx_t    ctx_o,
  output logic [15:0] sample_o
);

  logic [6:0]         idx_safe;
  logic [14:0]        step;
  logic signed [19:0] mag;
  logic signed [19:0] m;
  logic signed [19:0] diff;
  logic signed [17:0] sum;
  logic signed [16:0] pred_n;
  logic signed [8:0]  idx_sum;
  logic [6:0]         idx_n;

  // Scale the step by the nibble magnitude, apply sign, shift and saturate.
  always_comb begin
    idx_safe = (ctx_i.idx > 7'(STEP_IDX_MAX)) ? 7'(STEP_IDX_MAX) : ctx_i.idx;
    step     = 15'(STEP_TABLE[idx_safe]);
    // Multiplier is 1 + 8*n[2] + 4*n[1] + 2*n[0], i.e. {n[2:0],1}.
    mag      = $signed({5'd0, step}) * $signed({16'd0, nibble_i[2:0], 1'b1});
    m        = nibble_i[3] ? -mag : mag;
    diff     = m >>> 3;
    sum      = {ctx_i.pred[16], ctx_i.pred} + diff[17:0];
    if (sum > $signed({PRED_MAX[16], PRED_MAX})) begin
      pred_n = PRED_MAX;
    end else if (sum < $signed({PRED_MIN[16], PRED_MIN})) begin
      pred_n = PRED_MIN;
    end else begin
      pred_n = sum[16:0];
    end

    idx_sum = $signed({2'b00, idx_safe}) + $signed(9'(INDEX_TABLE[nibble_i]));
    if (idx_sum < 9'sd0) begin
      idx_n = 7'd0;
    end else if (idx_sum > 9'sd88) begin
      idx_n = 7'(STEP_IDX_MAX);
    end else begin
      idx_n = idx_sum[6:0];
    end

    ctx_o.pred = pred_n;
    ctx_o.idx  = idx_n;
    sample_o   = pred_n[15:0];
  end

endmodule

// File: rtl/ima_adpcm_ch_scheduler.sv
// Round-robin scheduler sharing one IMA ADPCM step across NUM_CH nibble
// streams. Keeps per-channel contexts and a single registered output slot.
// Optional macro ADPCM_CTX_LOAD_EN adds a context preload port (WAV block
// header): the loaded channel is masked from arbitration that cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. ch_ready_o is one-hot and depends only on ch_valid_i, the output
// slot state and out_ready_i (never on nibble/sop data). out_valid_o, out_ch_o
// and out_sample_o hold stable while out_valid_o=1 and out_ready_i=0.
module ima_adpcm_ch_scheduler
  import ima_adpcm_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ch_valid_i,
  input  logic [NUM_CH-1:0]   ch_sop_i,
  input  logic [4*NUM_CH-1:0] ch_nibble_i,
  output logic [NUM_CH-1:0]   ch_ready_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [CH_W-1:0]     out_ch_o,
  output logic [15:0]         out_sample_o
`ifdef ADPCM_CTX_LOAD_EN
  ,
  input  logic                ctx_load_i,
  input  logic [CH_W-1:0]     ctx_ch_i,
  input  logic [15:0]         ctx_pred_i,
  input  logic [6:0]          ctx_idx_i
`endif
);

  ima_ctx_t          ctx_q [NUM_CH];
  logic [CH_W-1:0]   rr_q;
  logic              out_valid_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [15:0]       out_sample_q;

  logic              can_issue;
  logic [NUM_CH-1:0] load_mask;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic              grant_any;
  logic [CH_W-1:0]   grant_id;
  logic [CH_W-1:0]   rr_next;

  ima_ctx_t          base_ctx;
  ima_ctx_t          new_ctx;
  logic [3:0]        sel_nibble;
  logic [15:0]       new_sample;

  function automatic int wrap_ch(input int v);
    return (v >= NUM_CH) ? v - NUM_CH : v;
  endfunction

  // Channel being preloaded this cycle is kept out of arbitration.
  always_comb begin
    load_mask = '0;
`ifdef ADPCM_CTX_LOAD_EN
    for (int c = 0; c < NUM_CH; c++) begin
      if (ctx_load_i && (ctx_ch_i == CH_W'(c))) begin
        load_mask[c] = 1'b1;
      end
    end
`endif
  end

  // Rotating-priority grant: first requester at or above rr_q, with wrap.
  always_comb begin
    can_issue = !out_valid_q || out_ready_i;
    req       = ch_valid_i & ~load_mask;
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    if (can_issue && !rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!grant_any && req[wrap_ch(int'(rr_q) + k)]) begin
          grant[wrap_ch(int'(rr_q) + k)] = 1'b1;
          grant_any = 1'b1;
          grant_id  = CH_W'(wrap_ch(int'(rr_q) + k));
        end
      end
    end
    rr_next = (grant_id == CH_W'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
  end

  // Select the granted channel's context; start-of-packet restarts it.
  always_comb begin
    base_ctx   = ctx_q[grant_id];
    if (ch_sop_i[grant_id]) begin
      base_ctx = '0;
    end
    sel_nibble = ch_nibble_i[{grant_id, 2'b00} +: 4];
  end

  ima_adpcm_step u_step (
    .ctx_i    (base_ctx),
    .nibble_i (sel_nibble),
    .ctx_o    (new_ctx),
    .sample_o (new_sample)
  );

  // Context write-back, rr pointer advance and output register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ctx_q[c] <= '0;
      end
      rr_q         <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_sample_q <= '0;
    end else begin
      if (grant_any) begin
        ctx_q[grant_id] <= new_ctx;
        rr_q            <= rr_next;
        out_valid_q     <= 1'b1;
        out_ch_q        <= grant_id;
        out_sample_q    <= new_sample;
      end else if (out_ready_i) begin
        out_valid_q     <= 1'b0;
      end
`ifdef ADPCM_CTX_LOAD_EN
      if (ctx_load_i && (int'(ctx_ch_i) < NUM_CH)) begin
        ctx_q[ctx_ch_i].pred <= {ctx_pred_i[15], ctx_pred_i};
        ctx_q[ctx_ch_i].idx  <= (ctx_idx_i > 7'(STEP_IDX_MAX)) ?
                                7'(STEP_IDX_MAX) : ctx_idx_i;
      end
`endif
    end
  end

  assign ch_ready_o   = grant;
  assign out_valid_o  = out_valid_q;
  assign out_ch_o     = out_ch_q;
  assign out_sample_o = out_sample_q;

endmodule

// File: tb/tb_ima_adpcm_ch_scheduler.sv
// Self-checking bench for ima_adpcm_ch_scheduler: randomized and directed
// stimulus against a behavioural IMA ADPCM model with an in-flight sample queue.
module tb_ima_adpcm_ch_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_CH-1:0]   ch_valid_i;
  logic [NUM_CH-1:0]   ch_sop_i;
  logic [4*NUM_CH-1:0] ch_nibble_i;
  logic [NUM_CH-1:0]   ch_ready_o;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [CH_W-1:0]     out_ch_o;
  logic [15:0]         out_sample_o;
`ifdef ADPCM_CTX_LOAD_EN
  logic                ctx_load_i;
  logic [CH_W-1:0]     ctx_ch_i;
  logic [15:0]         ctx_pred_i;
  logic [6:0]          ctx_idx_i;
`endif

  ima_adpcm_ch_scheduler #(.NUM_CH(NUM_CH)) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_valid_i   (ch_valid_i),
    .ch_sop_i     (ch_sop_i),
    .ch_nibble_i  (ch_nibble_i),
    .ch_ready_o   (ch_ready_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_ch_o     (out_ch_o),
    .out_sample_o (out_sample_o)
`ifdef ADPCM_CTX_LOAD_EN
    ,
    .ctx_load_i   (ctx_load_i),
    .ctx_ch_i     (ctx_ch_i),
    .ctx_pred_i   (ctx_pred_i),
    .ctx_idx_i    (ctx_idx_i)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int step_tab [89] = '{
        7,     8,     9,    10,    11,    12,    13,    14,    16,    17,
       19,    21,    23,    25,    28,    31,    34,    37,    41,    45,
       50,    55,    60,    66,    73,    80,    88,    97,   107,   118,
      130,   143,   157,   173,   190,   209,   230,   253,   279,   307,
      337,   371,   408,   449,   494,   544,   598,   658,   724,   796,
      876,   963,  1060,  1166,  1282,  1411,  1552,  1707,  1878,  2066,
     2272,  2499,  2749,  3024,  3327,  3660,  4026,  4428,  4871,  5358,
     5894,  6484,  7132,  7845,  8630,  9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };

  // Reference model state
  int m_pred [NUM_CH];
  int m_idx  [NUM_CH];
  int m_rr;
  logic [CH_W+15:0] exp_q [$];

  function automatic void ref_step(input int p, input int i, input int n,
                                   output int np, output int ni);
    int m;
    int d;
    int lo;
    m  = step_tab[i] * (2 * (n % 8) + 1);
    if (n >= 8) m = -m;
    d  = (m >= 0) ? m / 8 : -((-m + 7) / 8);
    np = p + d;
    if (np > 32767)  np = 32767;
    if (np < -32768) np = -32768;
    lo = n % 8;
    ni = i + ((lo < 4) ? -1 : 2 * (lo - 3));
    if (ni < 0)  ni = 0;
    if (ni > 88) ni = 88;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pred[c] = 0;
      m_idx[c]  = 0;
    end
    m_rr = 0;
    exp_q.delete();
  endtask

  // One clock of stimulus: check grant before the edge, outputs after it.
  task automatic run_cycle();
    int g;
    int np;
    int ni;
    int n;
    bit ld;
    int ld_ch;
    logic [NUM_CH-1:0] exp_rdy;
    ld = 1'b0;
    ld_ch = -1;
`ifdef ADPCM_CTX_LOAD_EN
    ld = ctx_load_i;
    ld_ch = int'(ctx_ch_i);
`endif
    #1;
    g = -1;
    if (exp_q.size() == 0 || out_ready_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (m_rr + k) % NUM_CH;
        if (g < 0 && ch_valid_i[c] && !(ld && ld_ch == c)) g = c;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    checks++;
    if (ch_ready_o !== exp_rdy) begin
      errors++;
      $display("FAIL ready: got %b exp %b", ch_ready_o, exp_rdy);
    end
    np = 0;
    ni = 0;
    if (g >= 0) begin
      n = int'(ch_nibble_i[4*g +: 4]);
      if (ch_sop_i[g]) ref_step(0, 0, n, np, ni);
      else             ref_step(m_pred[g], m_idx[g], n, np, ni);
    end
    @(posedge clk);
    if (exp_q.size() > 0 && out_ready_i) void'(exp_q.pop_front());
    if (g >= 0) begin
      m_pred[g] = np;
      m_idx[g]  = ni;
      m_rr      = (g + 1) % NUM_CH;
      exp_q.push_back({CH_W'(g), 16'(np)});
    end
`ifdef ADPCM_CTX_LOAD_EN
    if (ld) begin
      m_pred[ld_ch] = int'($signed(ctx_pred_i));
      m_idx[ld_ch]  = (ctx_idx_i > 7'd88) ? 88 : int'(ctx_idx_i);
    end
`endif
    #1;
    checks++;
    if (out_valid_o !== (exp_q.size() > 0)) begin
      errors++;
      $display("FAIL out_valid: got %b exp %b", out_valid_o, exp_q.size() > 0);
    end
    if (exp_q.size() > 0) begin
      checks++;
      if ({out_ch_o, out_sample_o} !== exp_q[0]) begin
        errors++;
        $display("FAIL out_data: got ch %0d smp %h exp ch %0d smp %h",
                 out_ch_o, out_sample_o, exp_q[0][CH_W+15:16], exp_q[0][15:0]);
      end
    end
  endtask

  task automatic drive(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] s,
                       input logic [4*NUM_CH-1:0] nib, input logic rdy);
    ch_valid_i  = v;
    ch_sop_i    = s;
    ch_nibble_i = nib;
    out_ready_i = rdy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive('1, '0, 16'(($urandom)), 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (ch_ready_o !== '0) begin
      errors++; $display("FAIL reset_ready: got %b exp 0", ch_ready_o);
    end
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b exp 0", out_valid_o);
    end
    checks++;
    if (out_ch_o !== '0 || out_sample_o !== 16'h0) begin
      errors++; $display("FAIL reset_out: got ch %0d smp %h exp 0 0", out_ch_o, out_sample_o);
    end
    model_reset();
    drive('0, '0, '0, 1'b1);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    drive(4'b0001, '0, 16'h0007, 1'b1);
    run_cycle();
    checks++;
    if (out_valid_o !== 1'b1 || out_ch_o !== 2'd0 || out_sample_o !== 16'd13) begin
      errors++; $display("FAIL basic_ch0: got v %b ch %0d smp %h exp 1 0 000d",
                         out_valid_o, out_ch_o, out_sample_o);
    end
    drive(4'b0010, '0, 16'h00F0, 1'b1);
    run_cycle();
    checks++;
    if (out_ch_o !== 2'd1 || out_sample_o !== 16'hFFF2) begin
      errors++; $display("FAIL basic_ch1: got ch %0d smp %h exp 1 fff2", out_ch_o, out_sample_o);
    end
    // ch0 context (pred 13, idx 8 -> step 16) must be untouched by ch1
    drive(4'b0001, '0, 16'h0000, 1'b1);
    run_cycle();
    checks++;
    if (out_ch_o !== 2'd0 || out_sample_o !== 16'd15) begin
      errors++; $display("FAIL basic_ctx: got ch %0d smp %h exp 0 000f", out_ch_o, out_sample_o);
    end
    drive('0, '0, '0, 1'b1);
    run_cycle();
  endtask

  task automatic test_round_robin();
    int cnt [NUM_CH];
    int start;
    for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
    start = m_rr;
    for (int k = 0; k < 4 * NUM_CH; k++) begin
      drive('1, '0, 16'($urandom), 1'b1);
      run_cycle();
      cnt[out_ch_o]++;
      checks++;
      if (int'(out_ch_o) != (start + k) % NUM_CH) begin
        errors++; $display("FAIL rr_order: got %0d exp %0d", out_ch_o, (start + k) % NUM_CH);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (cnt[c] != 4) begin
        errors++; $display("FAIL rr_share ch%0d: got %0d exp 4", c, cnt[c]);
      end
    end
    drive('0, '0, '0, 1'b1);
    run_cycle();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 100; k++) begin
      drive(4'b0100, '0, 16'h0700, 1'b1);
      run_cycle();
    end
    checks++;
    if (out_ch_o !== 2'd2 || out_sample_o !== 16'h7FFF) begin
      errors++; $display("FAIL sat_high: got ch %0d smp %h exp 2 7fff", out_ch_o, out_sample_o);
    end
    // idx at 88 -> step 32767; 0x8 subtracts 4096
    drive(4'b0100, '0, 16'h0800, 1'b1);
    run_cycle();
    checks++;
    if (out_sample_o !== 16'h6FFF) begin
      errors++; $display("FAIL sat_idx: got %h exp 6fff", out_sample_o);
    end
    drive('0, '0, '0, 1'b1);
    run_cycle();
  endtask

  task automatic test_backpressure();
    logic [15:0] held_smp;
    logic [CH_W-1:0] held_ch;
    drive('1, '0, 16'($urandom), 1'b1);
    run_cycle();
    held_smp = out_sample_o;
    held_ch  = out_ch_o;
    for (int k = 0; k < 3; k++) begin
      drive('1, '0, 16'($urandom), 1'b0);
      run_cycle();
      checks++;
      if (out_valid_o !== 1'b1 || out_sample_o !== held_smp || out_ch_o !== held_ch) begin
        errors++; $display("FAIL bp_hold: got v %b ch %0d smp %h exp 1 %0d %h",
                           out_valid_o, out_ch_o, out_sample_o, held_ch, held_smp);
      end
    end
    drive('1, '0, 16'($urandom), 1'b1);
    run_cycle();
    drive('0, '0, '0, 1'b1);
    run_cycle();
  endtask

  task automatic test_sop();
    drive(4'b0001, '0, 16'h0007, 1'b1);
    run_cycle();
    run_cycle();
    drive(4'b0001, 4'b0001, 16'h0007, 1'b1);
    run_cycle();
    checks++;
    if (out_ch_o !== 2'd0 || out_sample_o !== 16'd13) begin
      errors++; $display("FAIL sop_restart: got ch %0d smp %h exp 0 000d", out_ch_o, out_sample_o);
    end
    drive('0, '0, '0, 1'b1);
    run_cycle();
  endtask

`ifdef ADPCM_CTX_LOAD_EN
  task automatic test_load();
    ctx_load_i = 1'b1;
    ctx_ch_i   = 2'd0;
    ctx_pred_i = 16'd1000;
    ctx_idx_i  = 7'd100;
    drive(4'b0001, '0, 16'h0007, 1'b1);
    run_cycle();
    ctx_load_i = 1'b0;
    drive(4'b0001, '0, 16'h0000, 1'b1);
    run_cycle();
    checks++;
    if (out_ch_o !== 2'd0 || out_sample_o !== 16'd5095) begin
      errors++; $display("FAIL load_sample: got ch %0d smp %0d exp 0 5095", out_ch_o, out_sample_o);
    end
    run_cycle();
    drive('0, '0, '0, 1'b1);
    run_cycle();
  endtask
`endif

  task automatic test_random();
    logic [NUM_CH-1:0] sop;
    for (int k = 0; k < 400; k++) begin
      sop = '0;
      for (int c = 0; c < NUM_CH; c++) sop[c] = ($urandom_range(0, 7) == 0);
      drive(NUM_CH'($urandom), sop, 16'($urandom), ($urandom_range(0, 3) != 0));
`ifdef ADPCM_CTX_LOAD_EN
      ctx_load_i = ($urandom_range(0, 15) == 0);
      ctx_ch_i   = CH_W'($urandom);
      ctx_pred_i = 16'($urandom);
      ctx_idx_i  = 7'($urandom);
`endif
      run_cycle();
    end
`ifdef ADPCM_CTX_LOAD_EN
    ctx_load_i = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b1;
    drive('0, '0, '0, 1'b1);
`ifdef ADPCM_CTX_LOAD_EN
    ctx_load_i = 1'b0;
    ctx_ch_i   = '0;
    ctx_pred_i = '0;
    ctx_idx_i  = '0;
`endif
    model_reset();
    test_reset();
    test_basic();
    test_round_robin();
    test_reset();
    test_saturation();
    test_backpressure();
    test_sop();
`ifdef ADPCM_CTX_LOAD_EN
    test_load();
`endif
    test_random();
    // reset while a sample is likely in flight
    drive('1, '0, 16'($urandom), 1'b0);
    run_cycle();
    test_reset();
    drive('1, '0, 16'($urandom), 1'b1);
    run_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
